// File: rtl/debug_page_scheduler_pkg.sv
// Shared types and constants for the debug page scheduler.
package debug_pkg;

    typedef enum logic [1:0] {
        AUTO   = 2'd0,
        MANUAL = 2'd1,
        FROZEN = 2'd2
    } mode_t;

    localparam int PAGE_W     = 24;
    localparam int KEY_STEP   = 0;
    localparam int KEY_FREEZE = 1;
    localparam int KEY_AUTO   = 2;

endpackage

// File: rtl/debug_page_scheduler_key_debounce.sv
// One push-button: 2-flop synchronizer, debounce counter, single-cycle press pulse
// on each debounced release-to-press (1 -> 0) transition.
module key_debounce #(
    parameter int DB_CYC = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DB_CYC > 1) ? $clog2(DB_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synced input disagrees with the stable level,
    // so any bounce back to the stable level restarts the window.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                press_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= key_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/debug_page_scheduler.sv
// Rotates up to eight 24-bit debug pages onto the hex display, with auto dwell,
// manual stepping and a frozen snapshot mode driven by three debounced keys.
module debug_page_scheduler
    import debug_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int DWELL_MS    = 2000,
    parameter int DEBOUNCE_MS = 10,
    parameter int NUM_PAGES   = 8
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic [2:0]                  KEY,
    input  logic [PAGE_W*NUM_PAGES-1:0] page_data,
    input  logic [NUM_PAGES-1:0]        page_en,
    output logic [PAGE_W-1:0]           display_value,
    output logic [2:0]                  page_index,
    output logic [1:0]                  mode,
    output logic                        tick
);

    localparam int DWELL_CYC = CLK_HZ / 1000 * DWELL_MS;
    localparam int DB_CYC    = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int DW_W      = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYC - 1);

    logic [2:0]        press;
    logic              step_p, freeze_p, auto_p;
    mode_t             mode_q, mode_d;
    logic [2:0]        page_q, page_d, page_nxt;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [PAGE_W-1:0] disp_q, disp_d, live_data;
    logic              tick_q, tick_d;
    logic              cur_en;

    key_debounce #(.DB_CYC(DB_CYC)) u_key_step (
        .clk(CLOCK_50), .reset(reset), .key_n(KEY[KEY_STEP]), .press(press[KEY_STEP])
    );
    key_debounce #(.DB_CYC(DB_CYC)) u_key_freeze (
        .clk(CLOCK_50), .reset(reset), .key_n(KEY[KEY_FREEZE]), .press(press[KEY_FREEZE])
    );
    key_debounce #(.DB_CYC(DB_CYC)) u_key_auto (
        .clk(CLOCK_50), .reset(reset), .key_n(KEY[KEY_AUTO]), .press(press[KEY_AUTO])
    );

    assign auto_p   = press[KEY_AUTO];
    assign freeze_p = press[KEY_FREEZE] & ~press[KEY_AUTO];
    assign step_p   = press[KEY_STEP] & ~press[KEY_FREEZE] & ~press[KEY_AUTO];

    // First enabled page above cur (wrapping); cur itself if no other page is enabled.
    function automatic logic [2:0] next_enabled(input logic [2:0] cur,
                                                input logic [NUM_PAGES-1:0] en);
        logic [2:0] res;
        logic       found;
        int         j;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i < NUM_PAGES; i++) begin
            j = int'(cur) + i;
            if (j >= NUM_PAGES) j = j - NUM_PAGES;
            if (!found && en[j]) begin
                res   = 3'(j);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        live_data = '0;
        cur_en    = 1'b0;
        for (int p = 0; p < NUM_PAGES; p++) begin
            if (page_q == 3'(p)) begin
                live_data = page_data[p*PAGE_W +: PAGE_W];
                cur_en    = page_en[p];
            end
        end
    end

    assign page_nxt = next_enabled(page_q, page_en);

    always_comb begin
        mode_d  = mode_q;
        page_d  = page_q;
        dwell_d = dwell_q;
        tick_d  = 1'b0;
        case (mode_q)
            AUTO: begin
                if (auto_p) begin
                    dwell_d = '0;
                end else if (freeze_p) begin
                    mode_d = FROZEN;
                end else if (step_p) begin
                    mode_d  = MANUAL;
                    page_d  = page_nxt;
                    dwell_d = '0;
                end else if (dwell_q == DWELL_LAST) begin
                    tick_d  = 1'b1;
                    page_d  = page_nxt;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            MANUAL: begin
                dwell_d = '0;
                if (auto_p)        mode_d = AUTO;
                else if (freeze_p) mode_d = FROZEN;
                else if (step_p)   page_d = page_nxt;
            end
            FROZEN: begin
                if (auto_p) begin
                    mode_d  = AUTO;
                    dwell_d = '0;
                end else if (freeze_p) begin
                    mode_d = MANUAL;
                end
            end
            default: begin
                mode_d  = AUTO;
                dwell_d = '0;
            end
        endcase
        // Current page switched off while live: hop away silently.
        if (mode_q != FROZEN && mode_d != FROZEN && page_d == page_q && !cur_en)
            page_d = page_nxt;
    end

    always_comb begin
        disp_d = live_data;
        if (mode_d == FROZEN)    disp_d = disp_q;
        else if (page_en == '0)  disp_d = '0;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            mode_q  <= AUTO;
            page_q  <= '0;
            dwell_q <= '0;
            disp_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            page_q  <= page_d;
            dwell_q <= dwell_d;
            disp_q  <= disp_d;
            tick_q  <= tick_d;
        end
    end

    assign display_value = disp_q;
    assign page_index    = page_q;
    assign mode          = mode_q;
    assign tick          = tick_q;

endmodule

// File: doc/debug_page_scheduler.md
# debug_page_scheduler

Time-multiplexes up to eight 24-bit debug pages onto the six-digit seven-segment debug display. Pages advance automatically on a dwell timer or manually from push-buttons, and a snapshot can be frozen for reading. The block sits between the sensor/navigation signal bundle and the existing per-digit hex decoders: it drives the 24-bit value they display, and the page number and mode shown on LEDs.

## Interface
- `CLK_HZ`, 50_000_000, clock frequency in Hz.
- `DWELL_MS`, 2000, auto-advance dwell per page in ms; `DWELL_CYC = CLK_HZ/1000*DWELL_MS`.
- `DEBOUNCE_MS`, 10, button stability window in ms; `DB_CYC = CLK_HZ/1000*DEBOUNCE_MS`.
- `NUM_PAGES`, 8, number of pages, 2..8.
- `CLOCK_50`, in, 1, system clock. Single clock domain.
- `reset`, in, 1, synchronous, active-high.
- `KEY`, in, 3, raw push-buttons, active-low, asynchronous:
  - `KEY[0]` step to next page.
  - `KEY[1]` toggle freeze.
  - `KEY[2]` return to auto.
- `page_data`, in, 24*NUM_PAGES, page p occupies bits [24p+23:24p].
- `page_en`, in, NUM_PAGES, 1 = page selectable.
- `display_value`, out, 24, value for HEX5..HEX0, with HEX0 = bits [3:0].
- `page_index`, out, 3, current page.
- `mode`, out, 2, 0 = AUTO, 1 = MANUAL, 2 = FROZEN.
- `tick`, out, 1, one-cycle pulse on each auto advance.

## Operation
- **Button conditioning.** Each KEY bit gets:
  - a 2-flop synchronizer;
  - a debounce counter: the stable state updates only after the synced input differs from it for DB_CYC consecutive cycles;
  - a press pulse: one cycle on each stable 1→0 transition.
- **Press priority in the same cycle:** KEY[2] > KEY[1] > KEY[0]. Lower-priority pulses that cycle are discarded.
- **State machine.**
  - AUTO:
    - The dwell counter counts to DWELL_CYC-1, then pulses `tick`, advances to the next enabled page and clears.
    - step → MANUAL and advance immediately.
    - freeze → FROZEN.
    - auto → stay in AUTO and clear the dwell counter.
  - MANUAL:
    - The dwell counter is held at 0.
    - step → advance.
    - freeze → FROZEN.
    - auto → AUTO with the dwell counter cleared.
  - FROZEN:
    - `display_value` and `page_index` hold the snapshot. The dwell counter is held.
    - step is ignored.
    - freeze → MANUAL.
    - auto → AUTO with the dwell counter cleared.
- **Next-enabled search.** Scan upward from `page_index+1` with wrap-around from NUM_PAGES-1 to 0, and pick the first set `page_en` bit.
  - If only the current page is enabled, the index is unchanged. `tick` still pulses in AUTO.
  - If `page_en` is all zero, the index is unchanged, `display_value` is forced to 0 in AUTO/MANUAL, and `tick` still pulses.
- **Current page disabled at runtime.** If `page_en[page_index]` drops to 0 outside FROZEN, the block jumps to the next enabled page on the following cycle without pulsing `tick`.
- **Display.** Outside FROZEN, `display_value` = registered `page_data[page_index]`, sampled every cycle, so it is live data.
- **Freeze.** Entering FROZEN captures the `display_value` of the entry cycle.

## Timing
- **Reset** (synchronous, wins over everything):
  - `mode` = AUTO, `page_index` = 0, `display_value` = 0, `tick` = 0.
  - Dwell counter 0, debounce counters 0.
  - Stable key states 1 (released).
  - Reset mid-dwell or mid-debounce restarts both.
- **Press latency:** a KEY edge → press pulse after 2 synchronizer cycles + DB_CYC cycles. The mode/page update is registered on the pulse cycle, visible the next cycle.
- **Display latency:**
  - `display_value` reflects a new `page_index` one cycle after the index changes.
  - `page_data` changes appear one cycle later.
- **Dwell timing:**
  - First `tick` at exactly DWELL_CYC cycles after reset release.
  - Period DWELL_CYC thereafter.
  - `tick` is coincident with the `page_index` update.
- **Glitches:** a pulse shorter than DB_CYC cycles produces no press.

## Structure
- Package `debug_pkg`:
  - the `mode_t` enum (AUTO = 0, MANUAL = 1, FROZEN = 2);
  - the `PAGE_W = 24` constant;
  - the key index constants `KEY_STEP = 0`, `KEY_FREEZE = 1`, `KEY_AUTO = 2`.
- Sub-module `key_debounce`: synchronizer, debounce counter and press pulse for one bit, parameterized by DB_CYC. Instantiate it three times.
- Top-level contents: FSM, dwell counter, next-enabled search, and the output register.

## Test plan
All scenarios use CLK_HZ = 1000, DWELL_MS = 4 (DWELL_CYC = 4), DEBOUNCE_MS = 2 (DB_CYC = 2), and page p data = 0x1111*p + 0xA00000.
1. **Auto rotation:** reset, `page_en` = 0xFF → `tick` at cycles 4, 8, 12; `page_index` 1, 2, 3; `display_value` = 0xA01111 one cycle after index 1.
2. **Skip and wrap:** `page_en` = 0x81 → index sequence 0, 7, 0, 7. Then all-zero `page_en` → index held, `display_value` = 0.
3. **Manual step:** KEY[0] low for 5 cycles → press pulse after 4 cycles, `mode` = 1, index +1. Then no `tick` for 20 cycles.
4. **Freeze:** in MANUAL on page 3, KEY[1] press → `mode` = 2. Change `page_data` page 3 to 0 → `display_value` stays 0xA03333. KEY[0] press → ignored. KEY[1] press → `mode` = 1 and `display_value` = 0.
5. **Priority and glitch:** KEY[2] and KEY[0] pressed together from MANUAL → AUTO, index unchanged. A 1-cycle KEY[0] glitch → no press.
6. **Reset mid-dwell:** reset asserted at dwell count 2 in FROZEN → all outputs at reset values the next cycle; first `tick` 4 cycles after release.
